// File: rtl/adaptive_maxpool1d_scheduler_pkg.sv
// Shared definitions for the adaptive pooling schedulers: bin boundary math,
// signed max helper, counter sizing and the scheduler FSM encoding.
package adaptive_maxpool1d_scheduler_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } sched_state_t;

  // First element index of bin i: floor(i*L/O).
  function automatic int bin_start(input int i, input int l, input int o);
    return (i * l) / o;
  endfunction

  // One past the last element index of bin i: ceil((i+1)*L/O).
  function automatic int bin_end(input int i, input int l, input int o);
    return ((i + 1) * l + o - 1) / o;
  endfunction

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed max of two width-bit values carried zero-extended in MAX_W bits.
  // Shifting the sign bit to the top lets one signed compare serve any width.
  function automatic logic [MAX_W-1:0] smax(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input int width);
    logic signed [MAX_W-1:0] sa;
    logic signed [MAX_W-1:0] sb;
    sa = $signed(a << (MAX_W - width));
    sb = $signed(b << (MAX_W - width));
    return (sb > sa) ? b : a;
  endfunction

endpackage

// File: rtl/adaptive_maxpool1d_scheduler_if.sv
// Single-beat streaming channel shared by the pooling schedulers.
// A beat transfers on a rising clk edge where valid && ready; the master holds
// data and valid stable until that edge, and ready never waits on valid.
interface adaptive_maxpool1d_scheduler_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adaptive_maxpool1d_scheduler_out_reg.sv
// Single-entry valid/ready output register. A load in the same cycle as a
// drain reloads the register and keeps valid high, sustaining one beat/cycle.
module adaptive_maxpool1d_scheduler_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adaptive_maxpool1d_scheduler.sv
// Streaming adaptive 1-D max pool: one element in per beat, OUT_LEN bin maxima
// out per row, with adjacent bins sharing at most one boundary element.
module adaptive_maxpool1d_scheduler
  import adaptive_maxpool1d_scheduler_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  adaptive_maxpool1d_scheduler_if.slave         data_in_0,
  adaptive_maxpool1d_scheduler_if.master        data_out_0,
  output sched_state_t                          state
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int L  = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int R  = DATA_IN_0_TENSOR_SIZE_DIM_1;
  localparam int O  = DATA_OUT_0_TENSOR_SIZE_DIM_0;
  localparam int KW = cnt_width(L);
  localparam int BW = cnt_width(O);
  localparam int RW = cnt_width(R);

  if (O < 1 || O > L || R < 1 || W < 1 || W > MAX_W ||
      DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
      DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_bad_params
    $error("adaptive_maxpool1d_scheduler: illegal parameter combination");
  end

  logic [KW-1:0] k;
  logic [BW-1:0] b;
  logic [RW-1:0] r;
  logic [W-1:0]  acc;
  logic          acc_empty;

  logic          in_ready;
  logic          accept;
  logic          is_close;
  logic          shares;
  logic          last_elem;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [W-1:0]  m;
  logic [MAX_W-1:0] acc_ext;
  logic [MAX_W-1:0] x_ext;

  // Bin boundaries are elaboration constants: each bin contributes one
  // comparator against its closing index, so no runtime divide is needed.
  logic [O-1:0] close_hit;
  logic [O-1:0] shared_mask;

  for (genvar i = 0; i < O; i++) begin : g_bin
    assign close_hit[i]   = (b == BW'(i)) && (k == KW'(bin_end(i, L, O) - 1));
    assign shared_mask[i] = (i < O - 1) &&
                            (bin_end(i, L, O) - 1 >= bin_start(i + 1, L, O));
  end

  assign is_close  = |close_hit;
  assign shares    = |(close_hit & shared_mask);
  assign last_elem = (k == KW'(L - 1));

  assign in_ready        = !out_valid || data_out_0.ready;
  assign data_in_0.ready = in_ready;
  assign accept          = data_in_0.valid && in_ready;

  always_comb begin
    acc_ext          = '0;
    x_ext            = '0;
    acc_ext[W-1:0]   = acc;
    x_ext[W-1:0]     = data_in_0.data;
    m = acc_empty ? data_in_0.data : W'(smax(acc_ext, x_ext, W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      b         <= '0;
      r         <= '0;
      acc       <= '0;
      acc_empty <= 1'b1;
      state     <= ST_RUN;
    end else begin
      // STALL marks a cycle where a bin-closing element was held off.
      state <= (data_in_0.valid && !in_ready && is_close) ? ST_STALL : ST_RUN;
      if (accept) begin
        if (is_close) begin
          b         <= b + 1'b1;
          acc       <= data_in_0.data;
          acc_empty <= !shares;
        end else begin
          acc       <= m;
          acc_empty <= 1'b0;
        end
        if (last_elem) begin
          k         <= '0;
          b         <= '0;
          acc_empty <= 1'b1;
          r         <= (r == RW'(R - 1)) ? '0 : r + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  adaptive_maxpool1d_scheduler_out_reg #(
    .W(W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && is_close),
    .load_data (m),
    .out_ready (data_out_0.ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign data_out_0.valid = out_valid;
  assign data_out_0.data  = out_data;

endmodule

// File: tb/tb_adaptive_maxpool1d_scheduler.sv
// Bench for adaptive_maxpool1d_scheduler: several parameterisations side by
// side, a vector table, hand-written corner sequences and random rows.
module tb_adaptive_maxpool1d_scheduler;
  import adaptive_maxpool1d_scheduler_pkg::*;

  localparam int NU = 5;
  localparam int LS [NU] = '{8, 5, 2, 4, 5};
  localparam int OS [NU] = '{4, 3, 1, 4, 2};
  localparam int RS [NU] = '{1, 1, 1, 1, 3};
  localparam int NT = 8;

  typedef struct packed {
    int               u;
    int               n;
    logic [0:7][7:0]  v;
    int               ne;
    logic [0:3][7:0]  e;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [7:0]   din  [NU];
  logic         vin  [NU];
  logic         rin  [NU];
  logic         rout [NU];
  logic [7:0]   dout [NU];
  logic         vout [NU];
  sched_state_t st   [NU];

  logic [7:0] exp_q [$];
  logic [7:0] row   [$];
  vec_t       tbl   [NT];
  int         n_vec;
  int         n_fail;
  int         cur_u;
  bit         bp_en;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  for (genvar g = 0; g < NU; g++) begin : g_unit
    adaptive_maxpool1d_scheduler_if #(.W(8)) in_if ();
    adaptive_maxpool1d_scheduler_if #(.W(8)) out_if ();
    assign in_if.data   = din[g];
    assign in_if.valid  = vin[g];
    assign rin[g]       = in_if.ready;
    assign out_if.ready = rout[g];
    assign dout[g]      = out_if.data;
    assign vout[g]      = out_if.valid;

    adaptive_maxpool1d_scheduler #(
      .DATA_IN_0_PRECISION_0        (8),
      .DATA_IN_0_PRECISION_1        (3),
      .DATA_IN_0_TENSOR_SIZE_DIM_0  (LS[g]),
      .DATA_IN_0_TENSOR_SIZE_DIM_1  (RS[g]),
      .DATA_OUT_0_PRECISION_0       (8),
      .DATA_OUT_0_PRECISION_1       (3),
      .DATA_OUT_0_TENSOR_SIZE_DIM_0 (OS[g])
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in_0  (in_if),
      .data_out_0 (out_if),
      .state      (st[g])
    );
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic send(input int u, input logic [7:0] x);
    int n;
    bit took;
    n    = 0;
    took = 1'b0;
    din[u] = x;
    vin[u] = 1'b1;
    while (!took && n < 64) begin
      if (bp_en) rout[u] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = rin[u];
      @(posedge clk);
      #1;
      n++;
    end
    vin[u] = 1'b0;
    if (!took) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout unit %0d got no ready expected accept", u);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rout[cur_u] = 1'b1;
    while ((exp_q.size() != 0 || vout[cur_u]) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing got %0d results pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- reference model ----------------
  // Element j belongs to bin i exactly when j*O < (i+1)*L and (j+1)*O > i*L.
  task automatic golden(input logic [7:0] r_in [$], input int l, input int o);
    logic signed [7:0] mx;
    bit seen;
    for (int i = 0; i < o; i++) begin
      seen = 1'b0;
      mx   = '0;
      for (int j = 0; j < l; j++) begin
        if (j * o < (i + 1) * l && (j + 1) * o > i * l) begin
          if (!seen || $signed(r_in[j]) > mx) mx = $signed(r_in[j]);
          seen = 1'b1;
        end
      end
      exp_q.push_back(mx);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor();
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        if (vout[u] && rout[u]) begin
          n_vec++;
          if (exp_q.size() == 0 || u != cur_u) begin
            n_fail++;
            $display("FAIL out_unexpected unit %0d got %0h expected none", u, dout[u]);
          end else begin
            exp_v = exp_q.pop_front();
            if (dout[u] !== exp_v) begin
              n_fail++;
              $display("FAIL out_value unit %0d got %0h expected %0h", u, dout[u], exp_v);
            end
          end
        end
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int ru [4];
    n_vec  = 0;
    n_fail = 0;
    cur_u  = 0;
    bp_en  = 1'b0;
    ru     = '{4, 1, 0, 2};
    for (int u = 0; u < NU; u++) begin
      din[u]  = '0;
      vin[u]  = 1'b0;
      rout[u] = 1'b1;
    end

    tbl[0] = '{u: 0, n: 8, v: {8'h10, 8'hF8, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h05, 8'h05},
               ne: 4, e: {8'h10, 8'h7F, 8'h00, 8'h05}};
    tbl[1] = '{u: 1, n: 5, v: {8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd0, 8'd0, 8'd0},
               ne: 3, e: {8'd9, 8'd9, 8'd7, 8'd0}};
    tbl[2] = '{u: 1, n: 5, v: {8'hF0, 8'h80, 8'hF1, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00},
               ne: 3, e: {8'hF0, 8'hF1, 8'h80, 8'h00}};
    tbl[3] = '{u: 2, n: 2, v: {8'hF0, 8'h05, 48'h0}, ne: 1, e: {8'h05, 24'h0}};
    tbl[4] = '{u: 2, n: 2, v: {8'hF0, 8'h80, 48'h0}, ne: 1, e: {8'hF0, 24'h0}};
    tbl[5] = '{u: 2, n: 2, v: {8'h80, 8'h80, 48'h0}, ne: 1, e: {8'h80, 24'h0}};
    tbl[6] = '{u: 2, n: 2, v: {8'h7F, 8'h80, 48'h0}, ne: 1, e: {8'h7F, 24'h0}};
    tbl[7] = '{u: 3, n: 4, v: {8'h01, 8'hFF, 8'h80, 8'h7F, 32'h0},
               ne: 4, e: {8'h01, 8'hFF, 8'h80, 8'h7F}};

    rst = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      check($sformatf("rst_valid_u%0d", u), 8'(vout[u]), 8'd0);
      check($sformatf("rst_data_u%0d", u), dout[u], 8'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      check($sformatf("rst_ready_u%0d", u), 8'(rin[u]), 8'd1);
      check($sformatf("rst_state_u%0d", u), 8'(st[u]), 8'(ST_RUN));
    end

    // Ramp 1..8 at L=8/O=4: a result appears one cycle after every 2nd accept.
    cur_u = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) exp_q.push_back(8'(i + 1));
      send(0, 8'(i + 1));
      @(negedge clk);
      check($sformatf("lat_valid_%0d", i), 8'(vout[0]), 8'(i % 2));
      @(posedge clk);
      #1;
    end
    drain("lat");

    for (int t = 0; t < NT; t++) begin
      cur_u = tbl[t].u;
      for (int j = 0; j < tbl[t].ne; j++) exp_q.push_back(tbl[t].e[j]);
      for (int j = 0; j < tbl[t].n; j++) send(tbl[t].u, tbl[t].v[j]);
      drain($sformatf("tbl%0d", t));
    end

    // Backpressure at L=O=4: downstream stalls right after the first result.
    cur_u = 3;
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd30);
    exp_q.push_back(8'd40);
    din[3] = 8'd10;
    vin[3] = 1'b1;
    @(negedge clk);
    check("bp_ready0", 8'(rin[3]), 8'd1);
    @(posedge clk);
    #1;
    din[3] = 8'd20;
    @(negedge clk);
    check("bp_valid1", 8'(vout[3]), 8'd1);
    check("bp_data1", dout[3], 8'd10);
    check("bp_ready1", 8'(rin[3]), 8'd1);
    @(posedge clk);
    #1;
    din[3]  = 8'd30;
    rout[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_stall_ready_%0d", c), 8'(rin[3]), 8'd0);
      check($sformatf("bp_stall_valid_%0d", c), 8'(vout[3]), 8'd1);
      check($sformatf("bp_stall_data_%0d", c), dout[3], 8'd20);
      @(posedge clk);
      #1;
    end
    rout[3] = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", 8'(rin[3]), 8'd1);
    @(posedge clk);
    #1;
    din[3] = 8'd40;
    @(negedge clk);
    check("bp_data3", dout[3], 8'd30);
    @(posedge clk);
    #1;
    vin[3] = 1'b0;
    drain("bp");

    // Reset after 3 of 8 elements; the pending 120 must not leak into bin 0.
    cur_u = 0;
    exp_q.push_back(8'd101);
    send(0, 8'd100);
    send(0, 8'd101);
    send(0, 8'd120);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", 8'(vout[0]), 8'd0);
    check("midrst_data", dout[0], 8'd0);
    check("midrst_ready", 8'(rin[0]), 8'd1);
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 0) exp_q.push_back(8'(i));
      send(0, 8'(i));
    end
    drain("midrst");

    // Random signed rows with random downstream stalls.
    bp_en = 1'b1;
    for (int q = 0; q < 4; q++) begin
      cur_u = ru[q];
      for (int t = 0; t < 9; t++) begin
        row.delete();
        for (int j = 0; j < LS[cur_u]; j++) row.push_back(8'($urandom_range(0, 255)));
        golden(row, LS[cur_u], OS[cur_u]);
        for (int j = 0; j < LS[cur_u]; j++) send(cur_u, row[j]);
      end
      drain($sformatf("rand_u%0d", cur_u));
    end
    bp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adaptive_maxpool1d_scheduler.md
Name: adaptive_maxpool1d_scheduler

Overview:
Streaming controller that sequences 1-D adaptive max pooling over a serial element stream.
- Input: one element per handshake, rows of IN_LEN elements. Output: OUT_LEN pooled values per row.
- Computes adaptive bin boundaries, keeps a running max per bin, handles the one-element bin overlap, and applies valid/ready backpressure.
- Sits between a row-major tensor streamer and downstream MASE layers; replaces the fixed-window combinational pool wherever IN_LEN is not a multiple of OUT_LEN.

Parameters:
- DATA_IN_0_PRECISION_0, 8, total element width (signed fixed point).
- DATA_IN_0_PRECISION_1, 3, fractional bits. Pass-through only; must equal the output value.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 8, IN_LEN: elements per row. Must be ≥ 1.
- DATA_IN_0_TENSOR_SIZE_DIM_1, 1, number of rows (channels) per tensor.
- DATA_OUT_0_PRECISION_0, 8, must equal DATA_IN_0_PRECISION_0.
- DATA_OUT_0_PRECISION_1, 3, must equal DATA_IN_0_PRECISION_1.
- DATA_OUT_0_TENSOR_SIZE_DIM_0, 4, OUT_LEN: bins per row. Constraint: 1 ≤ OUT_LEN ≤ IN_LEN (elaboration assertion).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- data_in_0, input, DATA_IN_0_PRECISION_0, input element, signed.
- data_in_0_valid, input, 1, input element valid.
- data_in_0_ready, output, 1, scheduler can accept an element.
- data_out_0, output, DATA_OUT_0_PRECISION_0, pooled bin maximum, signed.
- data_out_0_valid, output, 1, output register holds a result.
- data_out_0_ready, input, 1, downstream accepts the result.

Behaviour:
- Bin i of a row spans [S(i), E(i)).
  - S(i) = floor(i*IN_LEN/OUT_LEN); E(i) = ceil((i+1)*IN_LEN/OUT_LEN).
  - Because IN_LEN ≥ OUT_LEN, E is strictly increasing and adjacent bins overlap by at most one element.
  - That overlapping element is always E(i)-1.
- State: element counter k (0..IN_LEN-1), bin counter b (0..OUT_LEN-1), row counter r, acc (running max), acc_empty flag, output register plus out_valid.
- FSM states:
  - RUN: accepting elements.
  - STALL: a bin-closing element is pending and the output register is full and not draining.
- Accept rule: data_in_0_ready = !out_valid || data_out_0_ready. Registered state is evaluated combinationally; no dependence on data_in_0_valid.
- On accept of x at index k:
  - Form m = acc_empty ? x : smax(acc, x). Comparison is signed.
  - If k == E(b)-1 (bin closes):
    - Output register <= m; out_valid <= 1; b++.
    - If k ≥ S(b+1), the element is shared: acc <= x, acc_empty <= 0. Otherwise acc_empty <= 1.
  - Else: acc <= m, acc_empty <= 0.
  - If k == IN_LEN-1: k <= 0, b <= 0, acc_empty <= 1, r++ (wraps at DIM_1-1 to 0).
- At most one bin closes per accepted element, so a single output register suffices.
- Latency: result is visible the cycle after the closing element's handshake.
- Output handshake: out_valid clears on data_out_0_ready, unless a new close occurs in the same cycle. In that case the register reloads and out_valid stays 1 (full throughput, 1 element per cycle).
- data_out_0 holds stable while out_valid && !data_out_0_ready.
- Reset (any time, including mid-row):
  - k, b, r = 0; acc_empty = 1; out_valid = 0; data_out_0 = 0.
  - data_in_0_ready = 1 the cycle after reset deasserts.
  - Partial bins are discarded.
- OUT_LEN == IN_LEN: every element closes its own bin and the block becomes a registered pass-through.
- OUT_LEN == 1: the single bin closes only at k = IN_LEN-1.

Decomposition:
- Shared package adaptive_pool_pkg holds:
  - Constant functions bin_start(i, L, O) and bin_end(i, L, O).
  - A function smax(a, b, width).
  - The counter-width localparams ($clog2 based).
- The boundaries are evaluated at elaboration into constant arrays S/E indexed by b; no runtime divider.
- One natural sub-module: adaptive_pool_out_reg, a single-entry valid/ready output register with the simultaneous load/drain rule. It can be reused by the future avgpool scheduler.

Test Plan:
- L=8, O=4, inputs 1..8, ready held 1 -> outputs 2, 4, 6, 8, each one cycle after the 2nd, 4th, 6th and 8th accept.
- L=5, O=3, inputs 3, 9, 1, 7, 2 -> outputs 9, 9, 7. Confirms shared elements 9 (k=1) and 7 (k=3) count in both bins.
- Signed: L=2, O=1, inputs 8'hF0, 8'h05 -> 8'h05. Inputs 8'hF0, 8'h80 -> 8'hF0.
- Backpressure: L=4, O=4, data_out_0_ready low for 3 cycles after the first result:
  - Only one further element is accepted; data_in_0_ready then drops.
  - data_out_0 holds stable; no result is lost or duplicated.
- Multi-row: DIM_1=3, L=5, O=2, random signed data -> 6 outputs matching the golden adaptive max per row; counters wrap cleanly.
- Reset mid-row after 3 of 8 elements, then a full row 1..8 at O=4 -> exactly 2, 4, 6, 8; no stale partial max appears.
